// File: rtl/crop_border_2d_pkg.sv
// Shared types for the HEVC pel-pipeline actors: context state, tag width, token layouts.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package hevc_actor_pkg;

  // Per-flux context state of a block-oriented actor.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ctx_state_e;

  // Tag width for a given flux count; a single flux still carries one tag bit.
  function automatic int tag_w(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  // Token layouts for the default pipeline configuration.
  localparam int DEF_FLUX   = 2;
  localparam int DEF_DATA_W = 18;
  localparam int DEF_SIZE_W = 7;
  localparam int DEF_TAG_W  = tag_w(DEF_FLUX);

  typedef struct packed {
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_SIZE_W-1:0] size;
  } size_tok_t;

  typedef struct packed {
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] pel;
  } pel_tok_t;

endpackage

// File: rtl/crop_border_2d_if.sv
// Multi-flux FIFO port bundles: read side (empty/dout/read) and write side (full/din/write).
// Latency: none, plain wires.
// Backpressure: empty/full flags are per flux; read is a per-flux pop strobe, write a single push.
interface fifo_rd_if #(
  parameter int FLUX = 2,
  parameter int W    = 8
);
  logic [FLUX-1:0] empty;
  logic [W-1:0]    dout;
  logic [FLUX-1:0] read;

  // master: the consuming actor; slave: the FIFO bank.
  modport master (input empty, input dout, output read);
  modport slave  (output empty, output dout, input read);
endinterface

interface fifo_wr_if #(
  parameter int FLUX = 2,
  parameter int W    = 8
);
  logic [FLUX-1:0] full;
  logic [W-1:0]    din;
  logic            write;

  // master: the producing actor; slave: the FIFO bank.
  modport master (input full, output din, output write);
  modport slave  (output full, input din, input write);
endinterface

// File: rtl/flux_rr_arbiter.sv
// Round-robin flux picker: eligible vector + last-grant pointer -> one-hot grant and index.
// Latency: purely combinational.
// Backpressure: n/a; gnt_vld_o is low when no flux is eligible.
// Ports: elig_i (per-flux request), ptr_i (last granted flux), gnt_o (one-hot),
//        gnt_idx_o (binary index of gnt_o), gnt_vld_o (any grant).
module flux_rr_arbiter
  import hevc_actor_pkg::*;
#(
  parameter int FLUX  = 2,
  parameter int IDX_W = tag_w(FLUX)
) (
  input  logic [FLUX-1:0]  elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [FLUX-1:0]  gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  int cand;

  // Search starts one past the last winner so a busy flux cannot starve the others.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = 0;
    for (int k = 1; k <= FLUX; k++) begin
      cand = (int'(ptr_i) + k) % FLUX;
      if (!gnt_vld_o && elig_i[cand]) begin
        gnt_vld_o   = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/crop_border_2d.sv
// Multi-flux border crop: per flux read block size S, consume S*S raster pels, forward the interior.
// Latency: zero; reads/write are combinational from context + flags, context updates on clk.
// Backpressure: out full stalls only kept pels of that flux; dropped pels drain regardless.
// Ports: clk, rst (async active-low); read_port_ext_size {tag,S} pops; read_port_in_pel {tag,pel}
//        pops; write_port_out_pel pushes {granted flux, pel}.
module crop_border_2d
  import hevc_actor_pkg::*;
#(
  parameter int FLUX     = 2,
  parameter int DATA_W   = 18,
  parameter int SIZE_W   = 7,
  parameter int BORDER_L = 4,
  parameter int BORDER_R = 4,
  parameter int BORDER_T = 4,
  parameter int BORDER_B = 4
) (
  input  logic      clk,
  input  logic      rst,
  fifo_rd_if.master read_port_ext_size,
  fifo_rd_if.master read_port_in_pel,
  fifo_wr_if.master write_port_out_pel
);

  localparam int TAG_W = tag_w(FLUX);
  // One spare bit so row+border never wraps; borders are assumed to fit in SIZE_W bits.
  localparam int CMP_W = SIZE_W + 1;
  localparam logic [CMP_W-1:0] BL_C = CMP_W'(BORDER_L);
  localparam logic [CMP_W-1:0] BR_C = CMP_W'(BORDER_R);
  localparam logic [CMP_W-1:0] BT_C = CMP_W'(BORDER_T);
  localparam logic [CMP_W-1:0] BB_C = CMP_W'(BORDER_B);

  ctx_state_e        state_q [FLUX];
  ctx_state_e        state_d [FLUX];
  logic [SIZE_W-1:0] s_q     [FLUX];
  logic [SIZE_W-1:0] s_d     [FLUX];
  logic [SIZE_W-1:0] row_q   [FLUX];
  logic [SIZE_W-1:0] row_d   [FLUX];
  logic [SIZE_W-1:0] col_q   [FLUX];
  logic [SIZE_W-1:0] col_d   [FLUX];
  logic [TAG_W-1:0]  ptr_q;
  logic [TAG_W-1:0]  ptr_d;

  logic [FLUX-1:0]   is_idle;
  logic [FLUX-1:0]   keep;
  logic [FLUX-1:0]   elig;
  logic [FLUX-1:0]   gnt;
  logic [TAG_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic [SIZE_W-1:0] new_s;

  // Incoming tags are not trusted; the granted index is the flux identity.
  logic unused_tags;
  assign unused_tags = ^{read_port_ext_size.dout[SIZE_W+TAG_W-1:SIZE_W],
                         read_port_in_pel.dout[DATA_W+TAG_W-1:DATA_W]};

  // Window test written additively (row+B < S rather than row < S-B) so a block
  // smaller than the borders keeps nothing instead of underflowing.
  always_comb begin
    is_idle = '0;
    keep    = '0;
    elig    = '0;
    for (int f = 0; f < FLUX; f++) begin
      is_idle[f] = (state_q[f] == IDLE);
      keep[f]    = (CMP_W'(row_q[f]) >= BT_C) &&
                   ((CMP_W'(row_q[f]) + BB_C) < CMP_W'(s_q[f])) &&
                   (CMP_W'(col_q[f]) >= BL_C) &&
                   ((CMP_W'(col_q[f]) + BR_C) < CMP_W'(s_q[f]));
      if (is_idle[f]) begin
        elig[f] = ~read_port_ext_size.empty[f];
      end else begin
        elig[f] = ~read_port_in_pel.empty[f] & (~keep[f] | ~write_port_out_pel.full[f]);
      end
    end
    // Nothing may be popped or pushed while reset is held.
    if (!rst) begin
      elig = '0;
    end
  end

  flux_rr_arbiter #(
    .FLUX  (FLUX),
    .IDX_W (TAG_W)
  ) u_arb (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Kept in separate assigns from the dout-consuming logic so reads never depend on dout.
  assign read_port_ext_size.read  = gnt & is_idle;
  assign read_port_in_pel.read    = gnt & ~is_idle;
  assign write_port_out_pel.write = gnt_vld & ~is_idle[gnt_idx] & keep[gnt_idx];
  assign write_port_out_pel.din   = {gnt_idx, read_port_in_pel.dout[DATA_W-1:0]};

  assign new_s = read_port_ext_size.dout[SIZE_W-1:0];

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    row_d   = row_q;
    col_d   = col_q;
    ptr_d   = ptr_q;
    if (gnt_vld) begin
      ptr_d = gnt_idx;
      if (is_idle[gnt_idx]) begin
        // S=0 is swallowed: the size is popped but no pels are expected.
        s_d[gnt_idx]     = new_s;
        row_d[gnt_idx]   = '0;
        col_d[gnt_idx]   = '0;
        state_d[gnt_idx] = (new_s != '0) ? STREAM : IDLE;
      end else if (col_q[gnt_idx] == (s_q[gnt_idx] - SIZE_W'(1))) begin
        col_d[gnt_idx] = '0;
        if (row_q[gnt_idx] == (s_q[gnt_idx] - SIZE_W'(1))) begin
          row_d[gnt_idx]   = '0;
          state_d[gnt_idx] = IDLE;
        end else begin
          row_d[gnt_idx] = row_q[gnt_idx] + SIZE_W'(1);
        end
      end else begin
        col_d[gnt_idx] = col_q[gnt_idx] + SIZE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < FLUX; f++) begin
        state_q[f] <= IDLE;
        s_q[f]     <= '0;
        row_q[f]   <= '0;
        col_q[f]   <= '0;
      end
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
